mem_group_dma_ctrl: RTL and testbench

// - Host-side transfer sequencer that loads and unloads MemoryGroup via its CPU port.
// - Accepts one burst command, then streams 60-bit words in (write) or out (read).
// - Drives cpu_interrupt, mb_sel, mem_sel, cpu_mem_sel_all, the core0 address/wr_en/din
//   of the selected block, and consumes cpu_dout.
// - Read path: credit-limited FIFO absorbs BRAM read latency under output backpressure.

---
 rtl/mem_group_dma_ctrl_if.sv | 41 ++++
 rtl/mem_group_dma_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_group_dma_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_group_dma_ctrl_if.sv
// rtl/mem_group_dma_ctrl_if.sv - command, stream and MemoryGroup CPU-port bundle
interface mem_group_dma_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [2:0]  cmd_mb;
  logic [3:0]  cmd_mem;
  logic        cmd_all;
  logic [10:0] cmd_base;
  logic [11:0] cmd_len;
  logic [59:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [59:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;
  logic        cpu_interrupt;
  logic        cpu_mem_sel_all;
  logic [2:0]  mb_sel;
  logic [3:0]  mem_sel;
  logic [10:0] mem_addr;
  logic        mem_wr_en;
  logic [59:0] mem_din;
  logic [59:0] mem_dout;

  modport slave (
    input  cmd_valid, cmd_dir, cmd_mb, cmd_mem, cmd_all, cmd_base, cmd_len,
           s_data, s_valid, m_ready, mem_dout,
    output cmd_ready, s_ready, m_data, m_valid, busy, done, cpu_interrupt,
           cpu_mem_sel_all, mb_sel, mem_sel, mem_addr, mem_wr_en, mem_din
  );

  modport master (
    output cmd_valid, cmd_dir, cmd_mb, cmd_mem, cmd_all, cmd_base, cmd_len,
           s_data, s_valid, m_ready, mem_dout,
    input  cmd_ready, s_ready, m_data, m_valid, busy, done, cpu_interrupt,
           cpu_mem_sel_all, mb_sel, mem_sel, mem_addr, mem_wr_en, mem_din
  );
endinterface

// File: rtl/mem_group_dma_ctrl.sv
// rtl/mem_group_dma_ctrl.sv - burst sequencer loading/unloading MemoryGroup via its CPU port
module mem_group_dma_ctrl #(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  mem_group_dma_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_FIN} state_t;
  state_t state_q, state_d;

  logic [10:0]       addr_q, wr_addr_q;
  logic [11:0]       remain_q;
  logic              wr_en_q, all_q;
  logic [59:0]       din_q;
  logic [2:0]        mb_q;
  logic [3:0]        mem_q;
  logic [RD_LAT-1:0] vld_q;
  logic [59:0]       fifo_q [FIFO_DEPTH];
  logic [AW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q, in_flight;
  logic              accept, reject, beat, issue, push, pop;

  assign accept    = (state_q == S_IDLE) && bus.cmd_valid;
  assign reject    = (bus.cmd_len == 12'd0) || (bus.cmd_mb == 3'd7);
  assign beat      = bus.s_ready && bus.s_valid;
  assign in_flight = CW'($countones(vld_q));
  // Credits cover both buffered words and reads still in the BRAM pipeline.
  assign issue     = (state_q == S_RD) && (remain_q != 12'd0) &&
                     (((CW+1)'(cnt_q) + (CW+1)'(in_flight)) < (CW+1)'(FIFO_DEPTH));
  assign push      = vld_q[RD_LAT-1];
  assign pop       = (cnt_q != '0) && bus.m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    bus.cmd_ready     = 1'b0;
    bus.busy          = 1'b1;
    bus.done          = 1'b0;
    bus.cpu_interrupt = 1'b0;
    bus.s_ready       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) state_d = reject ? S_FIN : (bus.cmd_dir ? S_RD : S_WR);
      end
      S_WR: begin
        bus.cpu_interrupt = 1'b1;
        bus.s_ready       = (remain_q != 12'd0);
        if (remain_q == 12'd0 && wr_en_q) state_d = S_FIN;
      end
      S_RD: begin
        bus.cpu_interrupt = 1'b1;
        if (issue && remain_q == 12'd1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        bus.cpu_interrupt = 1'b1;
        if (in_flight == '0 && cnt_q == '0) state_d = S_FIN;
      end
      S_FIN: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wr_addr_q <= '0;
      remain_q  <= '0;
      wr_en_q   <= 1'b0;
      all_q     <= 1'b0;
      din_q     <= '0;
      mb_q      <= '0;
      mem_q     <= '0;
      vld_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
    end else begin
      wr_en_q <= beat;
      if (beat) begin
        wr_addr_q <= addr_q;
        din_q     <= bus.s_data;
      end
      if (accept) begin
        addr_q   <= bus.cmd_base;
        remain_q <= bus.cmd_len;
        mb_q     <= bus.cmd_mb;
        mem_q    <= bus.cmd_mem;
        all_q    <= bus.cmd_all && !bus.cmd_dir && !reject;
      end else begin
        if (beat || issue) begin
          addr_q   <= addr_q + 11'd1;
          remain_q <= remain_q - 12'd1;
        end
        if (state_d == S_FIN) all_q <= 1'b0;
      end
      vld_q <= (vld_q << 1) | RD_LAT'(issue);
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= bus.mem_dout;
  end

  assign bus.m_valid         = (cnt_q != '0);
  assign bus.m_data          = (cnt_q != '0) ? fifo_q[rp_q] : '0;
  assign bus.mem_addr        = (state_q == S_RD) ? addr_q : wr_addr_q;
  assign bus.mem_wr_en       = wr_en_q;
  assign bus.mem_din         = din_q;
  assign bus.mb_sel          = mb_q;
  assign bus.mem_sel         = mem_q;
  assign bus.cpu_mem_sel_all = all_q;
endmodule

// File: tb/tb_mem_group_dma_ctrl.sv
// tb/tb_mem_group_dma_ctrl.sv - scoreboard bench for mem_group_dma_ctrl
module tb_mem_group_dma_ctrl;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_group_dma_ctrl_if bus();
  mem_group_dma_ctrl #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [10:0] addr;
    logic [59:0] data;
    logic        all;
  } wr_t;

  wr_t         exp_wr[$];
  logic [59:0] exp_rd[$];
  logic [59:0] wdata[$];
  logic [59:0] ref_mem [2048];
  logic [59:0] bram    [2048];
  logic [59:0] pipe    [RD_LAT];
  wr_t         mon_e;
  logic [59:0] mon_d;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  int last_wr_cyc = 0, rd_seen = 0, rd_first = 0, rd_last = 0;
  int mode = 0, acc_cyc = 0, done_at = 0;

  always @(posedge clk) cyc++;

  // Environment: BRAM with RD_LAT-cycle registered read
  always @(posedge clk) begin
    if (bus.mem_wr_en) bram[bus.mem_addr] <= bus.mem_din;
    pipe[0] <= bram[bus.mem_addr];
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.mem_dout = pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.mem_wr_en) begin
        chk("strobe_expected", 64'(exp_wr.size() > 0), 64'd1);
        if (exp_wr.size() > 0) begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", 64'(bus.mem_addr), 64'(mon_e.addr));
          chk("wr_data", 64'(bus.mem_din), 64'(mon_e.data));
          chk("wr_sel_all", 64'(bus.cpu_mem_sel_all), 64'(mon_e.all));
          chk("wr_irq", 64'(bus.cpu_interrupt), 64'd1);
          ref_mem[mon_e.addr] = mon_e.data;
          last_wr_cyc = cyc;
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        chk("rd_beat_expected", 64'(exp_rd.size() > 0), 64'd1);
        if (exp_rd.size() > 0) begin
          mon_d = exp_rd.pop_front();
          chk("rd_data", 64'(bus.m_data), 64'(mon_d));
          chk("rd_sel_all", 64'(bus.cpu_mem_sel_all), 64'd0);
        end
        if (rd_seen == 0) rd_first = cyc;
        rd_last = cyc;
        rd_seen++;
      end
      if (bus.done) done_cnt++;
    end
  end

  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  task automatic send_cmd(input logic dir, input logic [2:0] mb, input logic [3:0] mem,
                          input logic all, input logic [10:0] base, input logic [11:0] len);
    int n = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_dir = dir; bus.cmd_mb = mb; bus.cmd_mem = mem;
    bus.cmd_all = all; bus.cmd_base = base; bus.cmd_len = len;
    do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 50);
    chk("cmd_accept", 64'(bus.cmd_ready), 64'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic feed(input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      int n = 0;
      int g = gaps ? $urandom_range(0, 2) : 0;
      bus.s_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      bus.s_valid = 1'b1;
      bus.s_data  = wdata[i];
      do begin @(negedge clk); n++; end while (!bus.s_ready && n < 50);
      chk("s_ready", 64'(bus.s_ready), 64'd1);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.done && n < max);
    chk("done_seen", 64'(bus.done), 64'd1);
    done_at = cyc;
  endtask

  task automatic idle_after;
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_irq", 64'(bus.cpu_interrupt), 64'd0);
    chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("idle_sel_all", 64'(bus.cpu_mem_sel_all), 64'd0);
    chk("idle_m_valid", 64'(bus.m_valid), 64'd0);
  endtask

  task automatic do_write(input logic [2:0] mb, input logic [3:0] mem, input logic all,
                          input logic [10:0] base, input int len, input bit gaps);
    for (int i = 0; i < len; i++) exp_wr.push_back('{11'(int'(base) + i), wdata[i], all});
    send_cmd(1'b0, mb, mem, all, base, 12'(len));
    feed(len, gaps);
    wait_done(200);
    chk("wr_done_lat", 64'(done_at - last_wr_cyc), 64'd1);
    chk("wr_all_strobed", 64'(exp_wr.size()), 64'd0);
    idle_after();
  endtask

  task automatic do_read(input logic [2:0] mb, input logic [3:0] mem, input logic [10:0] base,
                         input int len, input int md, input bit stall);
    for (int i = 0; i < len; i++) exp_rd.push_back(ref_mem[11'(int'(base) + i)]);
    rd_seen = 0;
    mode = stall ? 2 : md;
    send_cmd(1'b1, mb, mem, 1'b1, base, 12'(len));
    if (stall) begin
      repeat (20) @(negedge clk);
      chk("stall_m_valid", 64'(bus.m_valid), 64'd1);
      chk("stall_no_beats", 64'(rd_seen), 64'd0);
      chk("stall_busy", 64'(bus.busy), 64'd1);
      chk("stall_no_wr", 64'(bus.mem_wr_en), 64'd0);
      mode = 0;
    end
    wait_done(2000);
    chk("rd_all_returned", 64'(exp_rd.size()), 64'd0);
    chk("rd_count", 64'(rd_seen), 64'(len));
    idle_after();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved, len;
    logic [10:0] base;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_mb = '0; bus.cmd_mem = '0;
    bus.cmd_all = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_irq", 64'(bus.cpu_interrupt), 64'd0);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_m_data", 64'(bus.m_data), 64'd0);
    chk("rst_wr_en", 64'(bus.mem_wr_en), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_din", 64'(bus.mem_din), 64'd0);
    chk("rst_sel", 64'({bus.cpu_mem_sel_all, bus.mb_sel, bus.mem_sel}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Address wrap at the top of the 2048-word space
    wdata = {60'd1, 60'd2, 60'd3, 60'd4};
    do_write(3'd2, 4'd3, 1'b0, 11'h7FE, 4, 1'b0);
    do_read(3'd2, 4'd3, 11'h7FE, 4, 0, 1'b0);
    chk("rd_back_to_back", 64'(rd_last - rd_first), 64'd3);

    // Output stalled long enough to exhaust read credits
    wdata.delete();
    for (int i = 0; i < 8; i++) wdata.push_back(60'({$urandom(), $urandom()}));
    do_write(3'd4, 4'd1, 1'b0, 11'h200, 8, 1'b0);
    do_read(3'd4, 4'd1, 11'h200, 8, 0, 1'b1);

    // Rejected commands: zero length and block 7
    send_cmd(1'b0, 3'd1, 4'd0, 1'b0, 11'h010, 12'd0);
    wait_done(10);
    chk("len0_done_lat", 64'((done_at - acc_cyc) inside {[1:2]}), 64'd1);
    idle_after();
    mode = 0;
    send_cmd(1'b1, 3'd7, 4'd0, 1'b0, 11'h010, 12'd5);
    wait_done(10);
    chk("mb7_done_lat", 64'((done_at - acc_cyc) inside {[1:2]}), 64'd1);
    idle_after();

    // Broadcast write
    wdata = {60'hABC, 60'hDEF};
    do_write(3'd0, 4'd5, 1'b1, 11'h040, 2, 1'b0);

    // Reset mid-write after three of six beats
    wdata.delete();
    for (int i = 0; i < 6; i++) wdata.push_back(60'(100 + i));
    for (int i = 0; i < 6; i++) exp_wr.push_back('{11'(11'h300 + i), wdata[i], 1'b0});
    send_cmd(1'b0, 3'd1, 4'd2, 1'b0, 11'h300, 12'd6);
    feed(3, 1'b0);
    saved = done_cnt;
    rst = 1'b1;
    #1;
    chk("abort_wr_en", 64'(bus.mem_wr_en), 64'd0);
    chk("abort_irq", 64'(bus.cpu_interrupt), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    exp_wr.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(saved));
    wdata = {60'h11, 60'h22, 60'h33};
    do_write(3'd1, 4'd2, 1'b0, 11'h300, 3, 1'b0);
    do_read(3'd1, 4'd2, 11'h300, 3, 0, 1'b0);

    // Randomised bursts with gappy input and random backpressure
    for (int it = 0; it < 6; it++) begin
      base = 11'($urandom_range(0, 2047));
      len  = $urandom_range(1, 24);
      wdata.delete();
      for (int i = 0; i < len; i++) wdata.push_back(60'({$urandom(), $urandom()}));
      do_write(3'($urandom_range(0, 6)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               base, len, 1'b1);
      do_read(3'($urandom_range(0, 6)), 4'($urandom_range(0, 15)), base, len, 1, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
